// File: rtl/inst_router_fifo_if.sv
// Dispatch-to-FU router bundle: input channel, wakeup bus, flush,
// per-FU head channels, occupancy and the sticky routing error flag.
// master = dispatch/issue side, slave = router.
interface inst_router_fifo_if #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int QUEUE_SIZE   = 4,
  parameter int FUC_BITS     = 2,
  parameter int NUM_FUS      = 4
);
  localparam int CW = $clog2(QUEUE_SIZE + 1);

  logic                                   flush;
  logic                                   in_valid;
  logic                                   in_ready;
  logic [INST_ID_BITS-1:0]                in_inst_id;
  logic [31:0]                            in_raw_instr;
  logic [63:0]                            in_instr_pc;
  logic [FUC_BITS-1:0]                    in_fu_choice;
  logic [MAX_OPERANDS-1:0]                in_prn_input_valid;
  logic [MAX_OPERANDS-1:0]                in_prn_input_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_prn_input;
  logic [MAX_OPERANDS-1:0]                in_prn_output_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  in_prn_output;
  logic                                   wake_valid;
  logic [PRN_BITS-1:0]                    wake_prn;

  logic [NUM_FUS-1:0]                     out_valid;
  logic [NUM_FUS-1:0]                     out_ready;
  logic [NUM_FUS-1:0][INST_ID_BITS-1:0]   out_inst_id;
  logic [NUM_FUS-1:0][31:0]               out_raw_instr;
  logic [NUM_FUS-1:0][63:0]               out_instr_pc;
  logic [NUM_FUS-1:0][MAX_OPERANDS-1:0]   out_prn_input_valid;
  logic [NUM_FUS-1:0][MAX_OPERANDS-1:0]   out_prn_input_ready;
  logic [NUM_FUS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn_input;
  logic [NUM_FUS-1:0][MAX_OPERANDS-1:0]   out_prn_output_valid;
  logic [NUM_FUS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn_output;
  logic [NUM_FUS-1:0][CW-1:0]             out_count;
  logic                                   route_err;

  modport master (
    output flush, in_valid, in_inst_id, in_raw_instr, in_instr_pc,
           in_fu_choice, in_prn_input_valid, in_prn_input_ready,
           in_prn_input, in_prn_output_valid, in_prn_output,
           wake_valid, wake_prn, out_ready,
    input  in_ready, out_valid, out_inst_id, out_raw_instr,
           out_instr_pc, out_prn_input_valid, out_prn_input_ready,
           out_prn_input, out_prn_output_valid, out_prn_output,
           out_count, route_err
  );

  modport slave (
    input  flush, in_valid, in_inst_id, in_raw_instr, in_instr_pc,
           in_fu_choice, in_prn_input_valid, in_prn_input_ready,
           in_prn_input, in_prn_output_valid, in_prn_output,
           wake_valid, wake_prn, out_ready,
    output in_ready, out_valid, out_inst_id, out_raw_instr,
           out_instr_pc, out_prn_input_valid, out_prn_input_ready,
           out_prn_input, out_prn_output_valid, out_prn_output,
           out_count, route_err
  );
endinterface

// File: rtl/inst_router_fifo.sv
// Steers renamed instructions into per-FU in-order FIFOs with wakeup.
// Ports: clk, rst (async, active-high), bus (inst_router_fifo_if.slave).
module inst_router_fifo #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int QUEUE_SIZE   = 4,
  parameter int FUC_BITS     = 2,
  parameter int NUM_FUS      = 4
) (
  input logic                 clk,
  input logic                 rst,
  inst_router_fifo_if.slave   bus
);
  localparam int PW = $clog2(QUEUE_SIZE);
  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_SIZE);

  logic [CW-1:0] count_q [NUM_FUS];
  logic [CW-1:0] count_d [NUM_FUS];
  logic [PW-1:0] head_q  [NUM_FUS];
  logic [PW-1:0] head_d  [NUM_FUS];
  logic [PW-1:0] tail_q  [NUM_FUS];
  logic [PW-1:0] tail_d  [NUM_FUS];
  logic          route_err_q, route_err_d;

  logic [INST_ID_BITS-1:0] id_q  [NUM_FUS][QUEUE_SIZE];
  logic [31:0]             raw_q [NUM_FUS][QUEUE_SIZE];
  logic [63:0]             pc_q  [NUM_FUS][QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0] piv_q [NUM_FUS][QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0] pir_q [NUM_FUS][QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0] pov_q [NUM_FUS][QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] pi_q [NUM_FUS][QUEUE_SIZE];
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] po_q [NUM_FUS][QUEUE_SIZE];

  logic [NUM_FUS-1:0]      push, pop;
  logic                    fu_ok, rdy;
  logic [MAX_OPERANDS-1:0] in_match;

  // in_ready looks only at registered occupancy; a pop this cycle
  // does not free a slot for a push until the next cycle.
  always_comb begin
    fu_ok = 1'b0;
    rdy   = 1'b0;
    push  = '0;
    pop   = '0;
    for (int k = 0; k < NUM_FUS; k++) begin
      if (bus.in_fu_choice == FUC_BITS'(k)) begin
        fu_ok = 1'b1;
        rdy   = (count_q[k] != FULL);
      end
      pop[k] = (count_q[k] != '0) && bus.out_ready[k];
    end
    for (int k = 0; k < NUM_FUS; k++) begin
      push[k] = bus.in_valid && rdy &&
                (bus.in_fu_choice == FUC_BITS'(k));
    end
  end

  always_comb begin
    in_match = '0;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      in_match[j] = bus.wake_valid && bus.in_prn_input_valid[j] &&
                    (bus.in_prn_input[j] == bus.wake_prn);
    end
  end

  always_comb begin
    route_err_d = route_err_q | (bus.in_valid & ~fu_ok);
    for (int k = 0; k < NUM_FUS; k++) begin
      head_d[k]  = head_q[k];
      tail_d[k]  = tail_q[k];
      count_d[k] = count_q[k];
      if (bus.flush) begin
        head_d[k]  = '0;
        tail_d[k]  = '0;
        count_d[k] = '0;
      end else begin
        if (push[k]) tail_d[k] = tail_q[k] + PW'(1);
        if (pop[k])  head_d[k] = head_q[k] + PW'(1);
        count_d[k] = count_q[k] + CW'(push[k]) - CW'(pop[k]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      route_err_q <= 1'b0;
      for (int k = 0; k < NUM_FUS; k++) begin
        head_q[k]  <= '0;
        tail_q[k]  <= '0;
        count_q[k] <= '0;
      end
    end else begin
      route_err_q <= route_err_d;
      for (int k = 0; k < NUM_FUS; k++) begin
        head_q[k]  <= head_d[k];
        tail_q[k]  <= tail_d[k];
        count_q[k] <= count_d[k];
      end
    end
  end

  // Storage needs no reset. Wakeup is applied to every slot; stale
  // slots are fully overwritten on their next push.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_FUS; k++) begin
      for (int e = 0; e < QUEUE_SIZE; e++) begin
        if (push[k] && tail_q[k] == PW'(e)) begin
          id_q[k][e]  <= bus.in_inst_id;
          raw_q[k][e] <= bus.in_raw_instr;
          pc_q[k][e]  <= bus.in_instr_pc;
          piv_q[k][e] <= bus.in_prn_input_valid;
          pir_q[k][e] <= bus.in_prn_input_ready | in_match;
          pi_q[k][e]  <= bus.in_prn_input;
          pov_q[k][e] <= bus.in_prn_output_valid;
          po_q[k][e]  <= bus.in_prn_output;
        end else if (bus.wake_valid) begin
          for (int j = 0; j < MAX_OPERANDS; j++) begin
            if (piv_q[k][e][j] && pi_q[k][e][j] == bus.wake_prn)
              pir_q[k][e][j] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.in_ready  = rdy;
    bus.route_err = route_err_q;
    for (int k = 0; k < NUM_FUS; k++) begin
      bus.out_valid[k]            = (count_q[k] != '0);
      bus.out_count[k]            = count_q[k];
      bus.out_inst_id[k]          = id_q[k][head_q[k]];
      bus.out_raw_instr[k]        = raw_q[k][head_q[k]];
      bus.out_instr_pc[k]         = pc_q[k][head_q[k]];
      bus.out_prn_input_valid[k]  = piv_q[k][head_q[k]];
      bus.out_prn_input_ready[k]  = pir_q[k][head_q[k]];
      bus.out_prn_input[k]        = pi_q[k][head_q[k]];
      bus.out_prn_output_valid[k] = pov_q[k][head_q[k]];
      bus.out_prn_output[k]       = po_q[k][head_q[k]];
    end
  end
endmodule

// File: tb/tb_inst_router_fifo.sv
// Self-checking bench for inst_router_fifo (NUM_FUS=3) against a
// queue-based reference model.
module tb_inst_router_fifo;
  localparam int IB = 6;
  localparam int PB = 6;
  localparam int MO = 3;
  localparam int QS = 4;
  localparam int FB = 2;
  localparam int NF = 3;
  localparam int CW = $clog2(QS + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_router_fifo_if #(
    .INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO),
    .QUEUE_SIZE(QS), .FUC_BITS(FB), .NUM_FUS(NF)
  ) bus ();

  inst_router_fifo #(
    .INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO),
    .QUEUE_SIZE(QS), .FUC_BITS(FB), .NUM_FUS(NF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [IB-1:0]         id;
    logic [31:0]           raw;
    logic [63:0]           pc;
    logic [MO-1:0]         piv;
    logic [MO-1:0]         pir;
    logic [MO-1:0][PB-1:0] pi;
    logic [MO-1:0]         pov;
    logic [MO-1:0][PB-1:0] po;
  } ent_t;

  ent_t mq [NF][$];
  bit   m_err;
  int   errors = 0;
  int   checks = 0;

  function automatic ent_t wk(ent_t e, logic v, logic [PB-1:0] p);
    for (int j = 0; j < MO; j++)
      if (v && e.piv[j] && e.pi[j] == p) e.pir[j] = 1'b1;
    return e;
  endfunction

  function automatic ent_t cur_in();
    ent_t e;
    e.id  = bus.in_inst_id;
    e.raw = bus.in_raw_instr;
    e.pc  = bus.in_instr_pc;
    e.piv = bus.in_prn_input_valid;
    e.pir = bus.in_prn_input_ready;
    e.pi  = bus.in_prn_input;
    e.pov = bus.in_prn_output_valid;
    e.po  = bus.in_prn_output;
    return e;
  endfunction

  task automatic drive_idle();
    bus.flush               = 1'b0;
    bus.in_valid            = 1'b0;
    bus.in_inst_id          = '0;
    bus.in_raw_instr        = '0;
    bus.in_instr_pc         = '0;
    bus.in_fu_choice        = '0;
    bus.in_prn_input_valid  = '0;
    bus.in_prn_input_ready  = '0;
    bus.in_prn_input        = '0;
    bus.in_prn_output_valid = '0;
    bus.in_prn_output       = '0;
    bus.wake_valid          = 1'b0;
    bus.wake_prn            = '0;
    bus.out_ready           = '0;
  endtask

  task automatic set_in(int f, int id, logic [MO-1:0] piv,
                        logic [MO-1:0] pir,
                        logic [MO-1:0][PB-1:0] pi);
    bus.in_valid            = 1'b1;
    bus.in_fu_choice        = FB'(f);
    bus.in_inst_id          = IB'(id);
    bus.in_raw_instr        = $urandom;
    bus.in_instr_pc         = {$urandom, $urandom};
    bus.in_prn_input_valid  = piv;
    bus.in_prn_input_ready  = pir;
    bus.in_prn_input        = pi;
    bus.in_prn_output_valid = MO'($urandom);
    bus.in_prn_output       = (MO*PB)'({$urandom, $urandom});
  endtask

  // Samples inputs before the edge, then advances the model after it.
  task automatic cycle();
    int            f;
    bit            acc;
    bit            pp [NF];
    ent_t          ne;
    logic          wv, fl, iv;
    logic [PB-1:0] wp;
    f   = int'(bus.in_fu_choice);
    iv  = bus.in_valid;
    fl  = bus.flush;
    wv  = bus.wake_valid;
    wp  = bus.wake_prn;
    acc = 1'b0;
    if (f < NF) acc = (mq[f].size() < QS);
    if (iv && f >= NF) m_err = 1'b1;
    for (int k = 0; k < NF; k++)
      pp[k] = (mq[k].size() > 0) && bus.out_ready[k];
    ne = wk(cur_in(), wv, wp);
    @(posedge clk);
    if (fl) begin
      for (int k = 0; k < NF; k++) mq[k].delete();
    end else begin
      for (int k = 0; k < NF; k++) begin
        if (pp[k]) void'(mq[k].pop_front());
        for (int i = 0; i < mq[k].size(); i++)
          mq[k][i] = wk(mq[k][i], wv, wp);
      end
      if (iv && acc) mq[f].push_back(ne);
    end
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int k = 0; k < NF; k++) mq[k].delete();
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== '0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out_count !== '0) begin
      errors++;
      $display("FAIL reset_count got=%h exp=0", bus.out_count);
    end
    checks++;
    if (bus.route_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got=%b exp=0", bus.route_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    set_in(2, 5, '0, '0, '0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_rdy got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 3'b000) begin
      errors++;
      $display("FAIL basic_nobypass got=%b exp=000", bus.out_valid);
    end
    cycle();
    drive_idle();
    checks++;
    if (bus.out_valid !== 3'b100) begin
      errors++;
      $display("FAIL basic_valid got=%b exp=100", bus.out_valid);
    end
    checks++;
    if (bus.out_inst_id[2] !== IB'(5)) begin
      errors++;
      $display("FAIL basic_id got=%0d exp=5", bus.out_inst_id[2]);
    end
    checks++;
    if (bus.out_count[2] !== CW'(1)) begin
      errors++;
      $display("FAIL basic_cnt got=%0d exp=1", bus.out_count[2]);
    end
    checks++;
    if (bus.out_instr_pc[2] !== mq[2][0].pc) begin
      errors++;
      $display("FAIL basic_pc got=%h exp=%h",
               bus.out_instr_pc[2], mq[2][0].pc);
    end
    bus.out_ready[2] = 1'b1;
    cycle();
    drive_idle();
    checks++;
    if (bus.out_valid !== 3'b000) begin
      errors++;
      $display("FAIL basic_pop got=%b exp=000", bus.out_valid);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 10 + i, '0, '0, '0);
      cycle();
    end
    drive_idle();
    bus.in_fu_choice = 2'd1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy1 got=%b exp=0", bus.in_ready);
    end
    bus.in_fu_choice = 2'd0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_rdy0 got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_count[1] !== CW'(4)) begin
      errors++;
      $display("FAIL full_cnt got=%0d exp=4", bus.out_count[1]);
    end
    checks++;
    if (bus.out_inst_id[1] !== IB'(10)) begin
      errors++;
      $display("FAIL full_head got=%0d exp=10", bus.out_inst_id[1]);
    end
    set_in(1, 14, '0, '0, '0);
    bus.out_ready[1] = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_poprdy got=%b exp=0", bus.in_ready);
    end
    cycle();
    checks++;
    if (bus.out_count[1] !== CW'(3)) begin
      errors++;
      $display("FAIL full_cnt3 got=%0d exp=3", bus.out_count[1]);
    end
    bus.out_ready[1] = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_retry got=%b exp=1", bus.in_ready);
    end
    cycle();
    drive_idle();
    checks++;
    if (bus.out_count[1] !== CW'(4)) begin
      errors++;
      $display("FAIL full_cnt4 got=%0d exp=4", bus.out_count[1]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_inst_id[1] !== IB'(11 + i)) begin
        errors++;
        $display("FAIL full_order got=%0d exp=%0d",
                 bus.out_inst_id[1], 11 + i);
      end
      bus.out_ready[1] = 1'b1;
      cycle();
    end
    drive_idle();
    checks++;
    if (bus.out_count[1] !== '0) begin
      errors++;
      $display("FAIL full_drain got=%0d exp=0", bus.out_count[1]);
    end
  endtask

  task automatic test_wakeup();
    logic [MO-1:0][PB-1:0] pi;
    pi    = '0;
    pi[0] = PB'(17);
    pi[1] = PB'(9);
    pi[2] = PB'(3);
    set_in(0, 20, 3'b011, 3'b000, pi);
    cycle();
    drive_idle();
    checks++;
    if (bus.out_prn_input_ready[0] !== 3'b000) begin
      errors++;
      $display("FAIL wake_pre got=%b exp=000",
               bus.out_prn_input_ready[0]);
    end
    pi    = '0;
    pi[0] = PB'(17);
    set_in(0, 21, 3'b001, 3'b000, pi);
    bus.wake_valid = 1'b1;
    bus.wake_prn   = PB'(17);
    cycle();
    drive_idle();
    checks++;
    if (bus.out_prn_input_ready[0] !== 3'b001) begin
      errors++;
      $display("FAIL wake_hit got=%b exp=001",
               bus.out_prn_input_ready[0]);
    end
    bus.wake_valid = 1'b1;
    bus.wake_prn   = PB'(3);
    cycle();
    drive_idle();
    checks++;
    if (bus.out_prn_input_ready[0] !== 3'b001) begin
      errors++;
      $display("FAIL wake_unused got=%b exp=001",
               bus.out_prn_input_ready[0]);
    end
    bus.out_ready[0] = 1'b1;
    cycle();
    drive_idle();
    checks++;
    if (bus.out_inst_id[0] !== IB'(21)) begin
      errors++;
      $display("FAIL wake_id got=%0d exp=21", bus.out_inst_id[0]);
    end
    checks++;
    if (bus.out_prn_input_ready[0] !== 3'b001) begin
      errors++;
      $display("FAIL wake_same got=%b exp=001",
               bus.out_prn_input_ready[0]);
    end
    bus.out_ready[0] = 1'b1;
    cycle();
    drive_idle();
  endtask

  task automatic test_route_err();
    bus.in_valid     = 1'b1;
    bus.in_fu_choice = 2'd3;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_rdy got=%b exp=0", bus.in_ready);
    end
    cycle();
    drive_idle();
    checks++;
    if (bus.route_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set got=%b exp=1", bus.route_err);
    end
    bus.flush = 1'b1;
    cycle();
    drive_idle();
    checks++;
    if (bus.route_err !== 1'b1) begin
      errors++;
      $display("FAIL err_flush got=%b exp=1", bus.route_err);
    end
  endtask

  task automatic test_flush();
    set_in(0, 40, '0, '0, '0);
    cycle();
    set_in(0, 41, '0, '0, '0);
    cycle();
    set_in(2, 42, '0, '0, '0);
    cycle();
    set_in(1, 30, '0, '0, '0);
    bus.flush        = 1'b1;
    bus.out_ready[0] = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_rdy got=%b exp=1", bus.in_ready);
    end
    cycle();
    drive_idle();
    checks++;
    if (bus.out_valid !== '0 || bus.out_count !== '0) begin
      errors++;
      $display("FAIL flush_clr got=%b/%h exp=0/0",
               bus.out_valid, bus.out_count);
    end
    set_in(2, 31, '0, '0, '0);
    cycle();
    drive_idle();
    checks++;
    if (bus.out_inst_id[2] !== IB'(31) ||
        bus.out_count[2] !== CW'(1)) begin
      errors++;
      $display("FAIL flush_after got=%0d/%0d exp=31/1",
               bus.out_inst_id[2], bus.out_count[2]);
    end
    set_in(0, 32, '0, '0, '0);
    cycle();
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== '0 || bus.out_count !== '0) begin
      errors++;
      $display("FAIL rst_mid got=%b/%h exp=0/0",
               bus.out_valid, bus.out_count);
    end
    checks++;
    if (bus.route_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got=%b exp=0", bus.route_err);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    bit      exp_rdy;
    int      f;
    ent_t    e;
    logic [MO-1:0][PB-1:0] pi;
    for (int n = 0; n < 400; n++) begin
      drive_idle();
      for (int j = 0; j < MO; j++) pi[j] = PB'($urandom_range(0, 7));
      f = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, NF - 1);
      set_in(f, $urandom, MO'($urandom), MO'($urandom), pi);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = NF'($urandom);
      bus.wake_valid = ($urandom_range(0, 2) == 0);
      bus.wake_prn   = PB'($urandom_range(0, 7));
      bus.flush      = ($urandom_range(0, 31) == 0);
      #1;
      exp_rdy = 1'b0;
      if (f < NF) exp_rdy = (mq[f].size() < QS);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_rdy n=%0d got=%b exp=%b",
                 n, bus.in_ready, exp_rdy);
      end
      cycle();
      checks++;
      if (bus.route_err !== m_err) begin
        errors++;
        $display("FAIL rnd_err n=%0d got=%b exp=%b",
                 n, bus.route_err, m_err);
      end
      for (int k = 0; k < NF; k++) begin
        checks++;
        if (bus.out_valid[k] !== (mq[k].size() > 0) ||
            bus.out_count[k] !== CW'(mq[k].size())) begin
          errors++;
          $display("FAIL rnd_occ n=%0d fu=%0d got=%b/%0d exp=%0d",
                   n, k, bus.out_valid[k], bus.out_count[k],
                   mq[k].size());
        end
        if (mq[k].size() > 0) begin
          e = mq[k][0];
          checks++;
          if ({bus.out_inst_id[k], bus.out_raw_instr[k],
               bus.out_instr_pc[k], bus.out_prn_input_valid[k],
               bus.out_prn_input_ready[k], bus.out_prn_input[k],
               bus.out_prn_output_valid[k], bus.out_prn_output[k]}
              !== {e.id, e.raw, e.pc, e.piv, e.pir, e.pi,
                   e.pov, e.po}) begin
            errors++;
            $display("FAIL rnd_head n=%0d fu=%0d got=%0d/%b exp=%0d/%b",
                     n, k, bus.out_inst_id[k],
                     bus.out_prn_input_ready[k], e.id, e.pir);
          end
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    model_clear();
    test_reset();
    test_basic();
    test_full();
    test_wakeup();
    test_route_err();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
